serial_addsub_flags: RTL
========================

Name: serial_addsub_flags

Overview:
- Multi-cycle adder/subtractor that sits directly upstream of the ALU comparator.
- Adds or subtracts two WIDTH-bit operands SLICE bits per cycle and produces the sum plus the N, V, C, Z flags that the comparator consumes for signed and unsigned less-than.
- Area-saving alternative to the single-cycle adder, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; latency N = WIDTH/SLICE.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operands and sub are valid.
- in_ready, output, 1, block can accept an operation.
- A, input, WIDTH, first operand.
- B, input, WIDTH, second operand.
- sub, input, 1, 1 = A-B, 0 = A+B.
- out_valid, output, 1, result and flags are valid.
- out_ready, input, 1, consumer accepts the result.
- result, output, WIDTH, A+B or A-B, modulo 2^WIDTH.
- FlagN, output, 1, result MSB.
- FlagV, output, 1, signed overflow.
- FlagC, output, 1, carry out of the MSB; for subtract, 1 means no borrow (A >= B unsigned).
- FlagZ, output, 1, result == 0 (see Optional Feature).

Behaviour:
- One clock (clk); reset is synchronous and active-low (reset_n), sampled on the rising clk edge.
- Reset state: IDLE; in_ready=1; out_valid=0; result=0; FlagN=FlagV=FlagC=FlagZ=0; slice counter=0; internal carry=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch A and Bx = sub ? ~B : B, set carry=sub, set counter=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle computes slice k: {c, s} = A[k] + Bx[k] + carry.
  - Writes s into result slice k, updates carry=c, increments the counter.
  - When k = N-1, also registers FlagC=c, FlagN=final result MSB, FlagV=(A[MSB]==Bx[MSB]) && (result MSB != A[MSB]), and FlagZ. Then go to DONE.
- DONE:
  - out_valid=1; result and flags are held stable.
  - On out_ready, go to IDLE (out_valid=0 the next cycle).
  - in_valid is ignored while in DONE.
- Latency: with acceptance at edge E0, out_valid rises after edge E_N (N cycles later). One bubble cycle after each handshake; maximum throughput is one operation per N+2 cycles.
- result and flags hold their last values in IDLE and are only meaningful while out_valid=1.
- Handshake rules:
  - No combinational path from in_valid to in_ready, or from out_ready to out_valid.
  - out_valid, once asserted, is never dropped without out_ready, except on reset.
- Reset mid-operation (RUN or DONE): returns to IDLE with reset values; any partial result is discarded, with no output handshake.
- Width rules: all arithmetic is modulo 2^WIDTH. Carry propagates between slices only through the registered carry bit.
- Degenerate case SLICE == WIDTH: N=1; RUN lasts exactly one cycle.
- Comparator contract: signed A<B = FlagN^FlagV; unsigned A<B = ~FlagC. Both are valid only after a subtract.

Optional Feature:
- Macro: ADDSUB_FLAGZ_EN.
- Defined: FlagZ is computed as the AND over slices of (slice result == 0), accumulated with a registered running-zero bit. It is registered with the other flags on the final slice.
- Undefined: the FlagZ port still exists but is tied to constant 0, and no zero-detect logic is built.

Test Plan:
- sub=1, A=5, B=7 -> after 4 cycles: result=0xFFFFFFFE, N=1, V=0, C=0, Z=0 (signed and unsigned less-than both true).
- sub=1, A=0x80000000, B=1 -> result=0x7FFFFFFF, N=0, V=1, C=1 (signed less-than true, unsigned false).
- sub=0, A=0xFFFFFFFF, B=1 -> result=0, C=1, V=0, N=0, Z=1 with ADDSUB_FLAGZ_EN defined, Z=0 without.
- sub=1, A=B=7 -> result=0, C=1, N=0, V=0, Z=1; also checks that the carry chain crosses all 4 slices.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not latched. After out_ready=1: IDLE, then the new operation is accepted.
- Assert reset_n=0 for one cycle during RUN slice 2 -> next cycle: in_ready=1, out_valid=0, all outputs 0. A subsequent 5-7 subtract yields the correct result.

Source files
------------

// File: rtl/serial_addsub_flags.sv
// Slice-serial adder/subtractor producing result plus N/V/C/Z flags for the ALU comparator.
// Define ADDSUB_FLAGZ_EN to build the zero-detect; otherwise FlagZ is tied to 0.
module serial_addsub_flags #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             FlagN,
    output logic             FlagV,
    output logic             FlagC,
    output logic             FlagZ,
    output logic [1:0]       o_state
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_bx;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_flag_n;
    logic             r_flag_v;
    logic             r_flag_c;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_bx_sl;
    logic [SLICE:0]   w_sum;
    logic             w_last;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready and out_valid are plain registers, so neither depends on the partner's signal.
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign FlagN     = r_flag_n;
    assign FlagV     = r_flag_v;
    assign FlagC     = r_flag_c;
    assign o_state   = r_state;

    always_comb begin
        w_a_sl  = '0;
        w_bx_sl = '0;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_sl  = r_a[k*SLICE +: SLICE];
                w_bx_sl = r_bx[k*SLICE +: SLICE];
            end
        end
    end

    assign w_sum  = {1'b0, w_a_sl} + {1'b0, w_bx_sl} + {{SLICE{1'b0}}, r_carry};
    assign w_last = (r_cnt == CW'(N - 1));

`ifdef ADDSUB_FLAGZ_EN
    logic r_zero;
    logic r_flag_z;
    logic w_slice_zero;
    assign w_slice_zero = (w_sum[SLICE-1:0] == '0);
    assign FlagZ        = r_flag_z;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_zero   <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_zero <= 1'b1;
        end else if (r_state == S_RUN) begin
            r_zero <= r_zero & w_slice_zero;
            if (w_last) begin
                r_flag_z <= r_zero & w_slice_zero;
            end
        end
    end
`else
    assign FlagZ = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_bx        <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_flag_n    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_flag_c    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                        r_a        <= A;
                        r_bx       <= sub ? ~B : B;
                        r_carry    <= sub;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (r_cnt == CW'(k)) begin
                            r_result[k*SLICE +: SLICE] <= w_sum[SLICE-1:0];
                        end
                    end
                    r_carry <= w_sum[SLICE];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_flag_c    <= w_sum[SLICE];
                        r_flag_n    <= w_sum[SLICE-1];
                        r_flag_v    <= (r_a[WIDTH-1] == r_bx[WIDTH-1]) &&
                                       (w_sum[SLICE-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
